// File: rtl/tx_sched_chan_reader_if.sv
// ---------------------------------------------------------------------------
// tx_sched_chan_reader_if
// Bundles the channel-FIFO handshake and the TX-chain sample bus of the
// per-channel TX packet reader.
//   master : the reader (pops FIFO words, drives samples)
//   slave  : FIFO + TX chain side (drives head word / strobe, consumes samples)
// Signals:
//   tx_strobe   TX chain requests the next sample
//   fifodata    show-ahead FIFO head word
//   pkt_waiting a complete packet is present, header at fifodata
//   rdreq       pop of the current fifodata word
//   skip        one-cycle pulse, discard rest of the current packet
//   tx_i/tx_q   MSB-aligned I/Q samples
//   tx_empty    TX chain must output zero
//   underrun    burst open but no packet waiting
// ---------------------------------------------------------------------------
interface tx_sched_chan_reader_if #(
   parameter int SAMPLE_WIDTH = 16
);
   logic                    tx_strobe;
   logic [31:0]             fifodata;
   logic                    pkt_waiting;
   logic                    rdreq;
   logic                    skip;
   logic [SAMPLE_WIDTH-1:0] tx_i;
   logic [SAMPLE_WIDTH-1:0] tx_q;
   logic                    tx_empty;
   logic                    underrun;

   modport master (
      input  tx_strobe, fifodata, pkt_waiting,
      output rdreq, skip, tx_i, tx_q, tx_empty, underrun
   );

   modport slave (
      output tx_strobe, fifodata, pkt_waiting,
      input  rdreq, skip, tx_i, tx_q, tx_empty, underrun
   );
endinterface

// File: rtl/tx_sched_chan_reader.sv
// ---------------------------------------------------------------------------
// tx_sched_chan_reader
// Per-channel TX packet reader. Pulls framed packets (header, timestamp,
// payload) from a show-ahead FIFO, holds each packet until its timestamp is
// within JITTER ticks ahead of adc_time (wrap-safe), optionally gates on RSSI
// with a timeout, and streams QI16 or packed QI8 samples on tx_strobe.
// Ports:
//   tx_clock, reset   clock, synchronous active-high reset
//   bus (master)      FIFO handshake + TX sample bus (see interface)
//   adc_time          current time
//   samples_format    0=QI16, 1=QI8 packed, others treated as QI16
//   rssi, threshhold  carrier-sense: transmit only when rssi <= threshhold
//   rssi_wait         carrier-sense timeout in cycles, 0 disables it
//   clr_stats         clears late_count (wins over an increment)
//   late_count        saturating count of discarded packets
//   state_dbg         current state encoding
// ---------------------------------------------------------------------------
module tx_sched_chan_reader #(
   parameter int TS_WIDTH     = 32,
   parameter int JITTER       = 5,
   parameter int SAMPLE_WIDTH = 16,
   parameter int STAT_WIDTH   = 16
) (
   input  logic                       tx_clock,
   input  logic                       reset,
   tx_sched_chan_reader_if.master     bus,
   input  logic [TS_WIDTH-1:0]        adc_time,
   input  logic [3:0]                 samples_format,
   input  logic [31:0]                rssi,
   input  logic [31:0]                threshhold,
   input  logic [31:0]                rssi_wait,
   input  logic                       clr_stats,
   output logic [STAT_WIDTH-1:0]      late_count,
   output logic [2:0]                 state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_HEADER     = 3'd1,
      S_TIMESTAMP  = 3'd2,
      S_WAIT       = 3'd3,
      S_WAITSTROBE = 3'd4,
      S_SEND       = 3'd5,
      S_SEND2      = 3'd6
   } state_t;

   localparam logic signed [TS_WIDTH-1:0] JIT = TS_WIDTH'(JITTER);

   // Place an 8/16-bit sample in the MSBs, zero-fill the LSBs.
   function automatic logic [SAMPLE_WIDTH-1:0] align8(input logic [7:0] v);
      align8 = '0;
      align8[SAMPLE_WIDTH-1 -: 8] = v;
   endfunction

   function automatic logic [SAMPLE_WIDTH-1:0] align16(input logic [15:0] v);
      align16 = '0;
      align16[SAMPLE_WIDTH-1 -: 16] = v;
   endfunction

   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      sat_inc = (&v) ? v : v + 1'b1;
   endfunction

   // Control state (reset)
   state_t                  state_q, state_d;
   logic                    rdreq_q, rdreq_d;
   logic                    skip_q, skip_d;
   logic                    tx_empty_q, tx_empty_d;
   logic                    underrun_q, underrun_d;
   logic [STAT_WIDTH-1:0]   late_q, late_d;
   logic                    burst_q, burst_d;
   logic                    trash_q, trash_d;
   logic                    rssi_flag_q, rssi_flag_d;
   logic [31:0]             time_wait_q, time_wait_d;
   logic [SAMPLE_WIDTH-1:0] tx_i_q, tx_i_d;
   logic [SAMPLE_WIDTH-1:0] tx_q_q, tx_q_d;

   // Datapath state (no reset; always written before being used)
   logic [TS_WIDTH-1:0]     ts_q, ts_d;
   logic [6:0]              len_q, len_d;
   logic [6:0]              wcnt_q, wcnt_d;
   logic [15:0]             held_q, held_d;

   // Timestamp window evaluation; diff is modular so adc_time wrap is safe.
   logic signed [TS_WIDTH-1:0] diff;
   logic ts_ones, ts_late, ts_in_win, rssi_timeout, rssi_ok;
   logic sob, eob;

   assign diff         = ts_q - adc_time;
   assign ts_ones      = &ts_q;
   assign ts_late      = !ts_ones && (diff[TS_WIDTH-1] || (diff == '0));
   assign ts_in_win    = !diff[TS_WIDTH-1] && (diff != '0) && (diff <= JIT);
   assign rssi_timeout = rssi_flag_q && (rssi_wait != 32'd0) && (time_wait_q >= rssi_wait);
   assign rssi_ok      = !rssi_flag_q || (rssi <= threshhold);
   assign sob          = bus.fifodata[28];
   assign eob          = bus.fifodata[27];

   always_comb begin
      state_d     = state_q;
      rdreq_d     = rdreq_q;
      skip_d      = skip_q;
      tx_empty_d  = tx_empty_q;
      underrun_d  = underrun_q;
      late_d      = late_q;
      burst_d     = burst_q;
      trash_d     = trash_q;
      rssi_flag_d = rssi_flag_q;
      time_wait_d = time_wait_q;
      tx_i_d      = tx_i_q;
      tx_q_d      = tx_q_q;
      ts_d        = ts_q;
      len_d       = len_q;
      wcnt_d      = wcnt_q;
      held_d      = held_q;

      // Outside the sample states a strobe with nothing to send means silence.
      if (bus.tx_strobe && (state_q != S_SEND) && (state_q != S_SEND2))
         tx_empty_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            skip_d      = 1'b0;
            time_wait_d = 32'd0;
            if (bus.pkt_waiting) begin
               state_d    = S_HEADER;
               rdreq_d    = 1'b1;
               underrun_d = 1'b0;
            end else if (burst_q) begin
               underrun_d = 1'b1;
            end
         end

         S_HEADER: begin
            rssi_flag_d = bus.fifodata[26] & sob;
            if (sob || eob)
               burst_d = sob && !eob;
            // A burst whose head was discarded is dropped until the next SOB.
            if (trash_q && !sob) begin
               skip_d  = 1'b1;
               rdreq_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               len_d   = bus.fifodata[8:2];
               wcnt_d  = 7'd0;
               rdreq_d = 1'b1;
               state_d = S_TIMESTAMP;
            end
         end

         S_TIMESTAMP: begin
            ts_d    = bus.fifodata[TS_WIDTH-1:0];
            rdreq_d = 1'b0;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            time_wait_d = time_wait_q + 32'd1;
            if (ts_late || rssi_timeout) begin
               trash_d = 1'b1;
               skip_d  = 1'b1;
               late_d  = sat_inc(late_q);
               state_d = S_IDLE;
            end else if ((ts_in_win || ts_ones) && rssi_ok) begin
               trash_d = 1'b0;
               state_d = S_WAITSTROBE;
            end
         end

         S_WAITSTROBE: begin
            if (wcnt_q == len_q) begin
               skip_d  = 1'b1;
               state_d = S_IDLE;
            end else if (bus.tx_strobe) begin
               rdreq_d = 1'b1;
               state_d = S_SEND;
            end
         end

         S_SEND: begin
            rdreq_d    = 1'b0;
            tx_empty_d = 1'b0;
            wcnt_d     = wcnt_q + 7'd1;
            if (samples_format == 4'd1) begin
               tx_i_d  = align8(bus.fifodata[7:0]);
               tx_q_d  = align8(bus.fifodata[15:8]);
               held_d  = bus.fifodata[31:16];
               state_d = S_SEND2;
            end else begin
               tx_i_d  = align16(bus.fifodata[15:0]);
               tx_q_d  = align16(bus.fifodata[31:16]);
               state_d = S_WAITSTROBE;
            end
         end

         S_SEND2: begin
            if (bus.tx_strobe) begin
               tx_i_d  = align8(held_q[7:0]);
               tx_q_d  = align8(held_q[15:8]);
               state_d = S_WAITSTROBE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (clr_stats)
         late_d = '0;
   end

   always_ff @(posedge tx_clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rdreq_q     <= 1'b0;
         skip_q      <= 1'b0;
         tx_empty_q  <= 1'b1;
         underrun_q  <= 1'b0;
         late_q      <= '0;
         burst_q     <= 1'b0;
         trash_q     <= 1'b0;
         rssi_flag_q <= 1'b0;
         time_wait_q <= 32'd0;
         tx_i_q      <= '0;
         tx_q_q      <= '0;
      end else begin
         state_q     <= state_d;
         rdreq_q     <= rdreq_d;
         skip_q      <= skip_d;
         tx_empty_q  <= tx_empty_d;
         underrun_q  <= underrun_d;
         late_q      <= late_d;
         burst_q     <= burst_d;
         trash_q     <= trash_d;
         rssi_flag_q <= rssi_flag_d;
         time_wait_q <= time_wait_d;
         tx_i_q      <= tx_i_d;
         tx_q_q      <= tx_q_d;
      end
   end

   always_ff @(posedge tx_clock) begin
      ts_q   <= ts_d;
      len_q  <= len_d;
      wcnt_q <= wcnt_d;
      held_q <= held_d;
   end

   assign bus.rdreq    = rdreq_q;
   assign bus.skip     = skip_q;
   assign bus.tx_i     = tx_i_q;
   assign bus.tx_q     = tx_q_q;
   assign bus.tx_empty = tx_empty_q;
   assign bus.underrun = underrun_q;
   assign late_count   = late_q;
   assign state_dbg    = state_q;

endmodule
